// File: rtl/des_key_bank.sv
// -----------------------------------------------------------------------------
// des_key_bank
//
// Holds the DES / 3DES key schedule inputs as a bank of 64-bit keys. Each key is
// loaded as two 32-bit words, low word first. The bank sits between the bus
// register decode (wr/data) and the DES datapath (q_all).
//
// Per-byte parity handling is chosen at build time by PARITY_MODE:
//   0 : bit0 of every byte is forced to 0
//   1 : bytes stored as written; a byte with even parity flags par_err
//   2 : bit0 of every byte is regenerated as odd parity over bits [7:1]
//
// In 2-key 3DES (key2_mode, three-key build only), key 2 mirrors key 0 and only
// four words are loaded. The storage for key 2 is left untouched, so dropping
// back to 3-key mode shows whatever was previously loaded there.
//
// Ports
//   hclk       in   1            clock, rising edge
//   hreset     in   1            synchronous active-high reset
//   zeroize    in   1            clear key words, write pointer and status
//   clr        in   1            clear write pointer and status, keep key words
//   key2_mode  in   1            2-key 3DES select (three-key build only)
//   wr         in   1            write strobe, one word per cycle
//   data       in   32           key word
//   q_all      out  64*NUM_KEYS  key i on [64*i+63:64*i]
//   key_valid  out  NUM_KEYS     both words of key i captured since last clear
//   all_valid  out  1            every key valid
//   par_err    out  NUM_KEYS     sticky even-parity byte seen in key i
//   ovf        out  1            sticky write received while bank full
// -----------------------------------------------------------------------------
module des_key_bank #(
  parameter int NUM_KEYS    = 3,
  parameter int PARITY_MODE = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    zeroize,
  input  logic                    clr,
  input  logic                    key2_mode,
  input  logic                    wr,
  input  logic [31:0]             data,
  output logic [64*NUM_KEYS-1:0]  q_all,
  output logic [NUM_KEYS-1:0]     key_valid,
  output logic                    all_valid,
  output logic [NUM_KEYS-1:0]     par_err,
  output logic                    ovf
);

  localparam int NUM_WORDS = 2 * NUM_KEYS;
  // Pointer must be able to hold NUM_WORDS itself (the "full" value).
  localparam int PW        = $clog2(NUM_WORDS + 1);

  localparam logic [PW-1:0] LIMIT_FULL = PW'(NUM_WORDS);
  localparam logic [PW-1:0] LIMIT_2KEY = PW'(4);

  logic [31:0]         words [NUM_WORDS];
  logic [PW-1:0]       wr_ptr;
  logic [NUM_KEYS-1:0] kv_q;
  logic [NUM_KEYS-1:0] par_err_q;
  logic                ovf_q;

  logic                key2_eff;
  logic [PW-1:0]       limit;
  logic                accept;
  logic [31:0]         data_fixed;
  logic                byte_even;

  // key2_mode only means something when there is a third key to mirror.
  assign key2_eff = (NUM_KEYS == 3) && key2_mode;
  assign limit    = key2_eff ? LIMIT_2KEY : LIMIT_FULL;
  assign accept   = wr && (wr_ptr < limit);

  // Parity transform applied to the incoming word before storage.
  always_comb begin
    data_fixed = data;
    byte_even  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      case (PARITY_MODE)
        0:       data_fixed[8*b +: 8] = {data[8*b+1 +: 7], 1'b0};
        2:       data_fixed[8*b +: 8] = {data[8*b+1 +: 7], ~^data[8*b+1 +: 7]};
        default: data_fixed[8*b +: 8] = data[8*b +: 8];
      endcase
      if (~^data[8*b +: 8]) begin
        byte_even = 1'b1;
      end
    end
    if (PARITY_MODE != 1) begin
      byte_even = 1'b0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset || zeroize) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        words[i] <= 32'h0;
      end
      wr_ptr    <= '0;
      kv_q      <= '0;
      par_err_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      kv_q      <= '0;
      par_err_q <= '0;
      ovf_q     <= 1'b0;
    end else if (wr) begin
      if (accept) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (wr_ptr == PW'(i)) begin
            words[i] <= data_fixed;
          end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
          // High word of key k completes it.
          if (wr_ptr == PW'(2 * k + 1)) begin
            kv_q[k] <= 1'b1;
          end
          if (byte_even && (wr_ptr >> 1) == PW'(k)) begin
            par_err_q[k] <= 1'b1;
          end
        end
        wr_ptr <= wr_ptr + PW'(1);
      end else begin
        // Pointer at (or, after a key2_mode change, beyond) the limit.
        ovf_q <= 1'b1;
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      if (k == 2) begin : g_mirror
        assign q_all[64*k +: 64] = key2_eff ? {words[1], words[0]}
                                            : {words[2*k+1], words[2*k]};
        assign key_valid[k]      = key2_eff ? kv_q[0] : kv_q[k];
      end else begin : g_plain
        assign q_all[64*k +: 64] = {words[2*k+1], words[2*k]};
        assign key_valid[k]      = kv_q[k];
      end
    end
  endgenerate

  assign all_valid = &key_valid;
  assign par_err   = par_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_des_key_bank.sv
module tb_des_key_bank;

  logic         hclk = 1'b0;
  logic         hreset, zeroize, clr, key2_mode, wr;
  logic [31:0]  data;

  logic [191:0] q0, q1, q2;
  logic [63:0]  q3;
  logic [2:0]   kv0, kv1, kv2, pe0, pe1, pe2;
  logic [0:0]   kv3, pe3;
  logic         av0, av1, av2, av3, ov0, ov1, ov2, ov3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 hclk = ~hclk;

  des_key_bank #(.NUM_KEYS(3), .PARITY_MODE(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .zeroize(zeroize), .clr(clr), .key2_mode(key2_mode),
    .wr(wr), .data(data), .q_all(q0), .key_valid(kv0), .all_valid(av0),
    .par_err(pe0), .ovf(ov0));
  des_key_bank #(.NUM_KEYS(3), .PARITY_MODE(1)) dut1 (
    .hclk(hclk), .hreset(hreset), .zeroize(zeroize), .clr(clr), .key2_mode(key2_mode),
    .wr(wr), .data(data), .q_all(q1), .key_valid(kv1), .all_valid(av1),
    .par_err(pe1), .ovf(ov1));
  des_key_bank #(.NUM_KEYS(3), .PARITY_MODE(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .zeroize(zeroize), .clr(clr), .key2_mode(key2_mode),
    .wr(wr), .data(data), .q_all(q2), .key_valid(kv2), .all_valid(av2),
    .par_err(pe2), .ovf(ov2));
  des_key_bank #(.NUM_KEYS(1), .PARITY_MODE(0)) dut3 (
    .hclk(hclk), .hreset(hreset), .zeroize(zeroize), .clr(clr), .key2_mode(key2_mode),
    .wr(wr), .data(data), .q_all(q3), .key_valid(kv3), .all_valid(av3),
    .par_err(pe3), .ovf(ov3));

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    wr   = 1'b1;
    data = d;
    tick();
    wr   = 1'b0;
    data = 32'h0;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (q0 !== 192'h0) $display("FAIL reset_q got %h exp 0", q0); else n_pass++;
    n_total++; if (kv0 !== 3'b000) $display("FAIL reset_kv got %b exp 000", kv0); else n_pass++;
    n_total++; if ({av0, ov0, pe0} !== 5'b0) $display("FAIL reset_status got %b exp 00000", {av0, ov0, pe0}); else n_pass++;
    n_total++; if ({q3, kv3, av3, ov3} !== 67'h0) $display("FAIL reset_single got %h exp 0", {q3, kv3, av3, ov3}); else n_pass++;
  endtask

  // Six all-ones words; mode 0 clears bit0 of every byte.
  task automatic test_load_mode0();
    logic [2:0] exp_kv [6];
    exp_kv = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      write_word(32'hFFFF_FFFF);
      n_total++;
      if (kv0 !== exp_kv[i]) $display("FAIL load_kv_w%0d got %b exp %b", i, kv0, exp_kv[i]); else n_pass++;
    end
    n_total++; if (q0 !== {3{64'hFEFEFEFE_FEFEFEFE}}) $display("FAIL load_q got %h exp FEFE..", q0); else n_pass++;
    n_total++; if (av0 !== 1'b1) $display("FAIL load_all_valid got %b exp 1", av0); else n_pass++;
    n_total++; if (ov0 !== 1'b0) $display("FAIL load_ovf got %b exp 0", ov0); else n_pass++;
    // Single-DES bank filled after two words; the remaining four overflow.
    n_total++; if (q3 !== 64'hFEFEFEFE_FEFEFEFE) $display("FAIL single_q got %h exp FEFEFEFEFEFEFEFE", q3); else n_pass++;
    n_total++; if ({kv3, av3, ov3} !== 3'b111) $display("FAIL single_status got %b exp 111", {kv3, av3, ov3}); else n_pass++;
  endtask

  task automatic test_overflow_clr();
    write_word(32'h1234_5678);
    n_total++; if (q0 !== {3{64'hFEFEFEFE_FEFEFEFE}}) $display("FAIL ovf_q got %h exp FEFE..", q0); else n_pass++;
    n_total++; if (ov0 !== 1'b1) $display("FAIL ovf_set got %b exp 1", ov0); else n_pass++;
    clr = 1'b1; tick(); clr = 1'b0;
    n_total++; if ({ov0, kv0, av0} !== 5'b0) $display("FAIL clr_status got %b exp 00000", {ov0, kv0, av0}); else n_pass++;
    n_total++; if (q0 !== {3{64'hFEFEFEFE_FEFEFEFE}}) $display("FAIL clr_keeps_q got %h exp FEFE..", q0); else n_pass++;
    // Pointer back at 0: next word overwrites word 0 only.
    write_word(32'h0000_0010);
    n_total++; if (q0[63:0] !== 64'hFEFEFEFE_00000010) $display("FAIL clr_ptr got %h exp FEFEFEFE00000010", q0[63:0]); else n_pass++;
  endtask

  task automatic test_parity_check();
    do_reset();
    write_word(32'h0102_0380);
    n_total++; if (pe1 !== 3'b001) $display("FAIL par_err_w0 got %b exp 001", pe1); else n_pass++;
    n_total++; if (q1[31:0] !== 32'h0102_0380) $display("FAIL par_store got %h exp 01020380", q1[31:0]); else n_pass++;
    n_total++; if (q0[31:0] !== 32'h0002_0280) $display("FAIL mode0_store got %h exp 00020280", q0[31:0]); else n_pass++;
    n_total++; if (pe0 !== 3'b000) $display("FAIL mode0_par_err got %b exp 000", pe0); else n_pass++;
    write_word(32'h0101_0101);
    n_total++; if (pe1 !== 3'b001) $display("FAIL par_err_w1 got %b exp 001", pe1); else n_pass++;
    write_word(32'h00FF_FFFF);
    n_total++; if (pe1 !== 3'b011) $display("FAIL par_err_w2 got %b exp 011", pe1); else n_pass++;
  endtask

  task automatic test_two_key();
    do_reset();
    key2_mode = 1'b1;
    write_word(32'h1020_3040);
    write_word(32'h5060_7080);
    write_word(32'hA0B0_C0D0);
    write_word(32'hE0F0_0200);
    n_total++; if (kv0 !== 3'b111 || av0 !== 1'b1) $display("FAIL k2_valid got %b/%b exp 111/1", kv0, av0); else n_pass++;
    n_total++; if (q0[191:128] !== 64'h50607080_10203040) $display("FAIL k2_key2 got %h exp 5060708010203040", q0[191:128]); else n_pass++;
    n_total++; if (q0[127:64] !== 64'hE0F00200_A0B0C0D0) $display("FAIL k2_key1 got %h exp E0F00200A0B0C0D0", q0[127:64]); else n_pass++;
    n_total++; if (ov0 !== 1'b0) $display("FAIL k2_ovf_early got %b exp 0", ov0); else n_pass++;
    write_word(32'h4444_4444);
    n_total++; if (ov0 !== 1'b1) $display("FAIL k2_ovf got %b exp 1", ov0); else n_pass++;
    n_total++; if (q0[191:128] !== 64'h50607080_10203040) $display("FAIL k2_ovf_q got %h exp 5060708010203040", q0[191:128]); else n_pass++;
    // Leaving 2-key mode exposes untouched key-2 storage.
    key2_mode = 1'b0;
    #1;
    n_total++; if (q0[191:128] !== 64'h0) $display("FAIL k2_off_q got %h exp 0", q0[191:128]); else n_pass++;
    n_total++; if (kv0 !== 3'b011 || av0 !== 1'b0) $display("FAIL k2_off_valid got %b/%b exp 011/0", kv0, av0); else n_pass++;
  endtask

  task automatic test_regen_and_midreset();
    do_reset();
    write_word(32'h0000_0000);
    write_word(32'hFFFF_FFFF);
    write_word(32'h0303_0303);
    n_total++; if (q2[63:0] !== 64'hFEFEFEFE_01010101) $display("FAIL regen_key0 got %h exp FEFEFEFE01010101", q2[63:0]); else n_pass++;
    n_total++; if (q2[95:64] !== 32'h0202_0202) $display("FAIL regen_w2 got %h exp 02020202", q2[95:64]); else n_pass++;
    do_reset();
    n_total++; if (q2 !== 192'h0 || kv2 !== 3'b0) $display("FAIL midreset got %h/%b exp 0/000", q2, kv2); else n_pass++;
    write_word(32'hAAAA_AAAA);
    n_total++; if (q2[63:0] !== 64'h00000000_ABABABAB) $display("FAIL midreset_ptr got %h exp 00000000ABABABAB", q2[63:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr = 1'b1; clr = 1'b1; data = 32'h1234_5678;
    tick();
    wr = 1'b0; clr = 1'b0;
    n_total++; if (q0 !== 192'h0) $display("FAIL wr_clr_drop got %h exp 0", q0); else n_pass++;
    write_word(32'h2222_2222);
    n_total++; if (q0[63:0] !== 64'h00000000_22222222) $display("FAIL wr_clr_ptr got %h exp 0000000022222222", q0[63:0]); else n_pass++;
    for (int i = 1; i < 6; i++) write_word(32'h2222_2222 + i * 32'h0202_0202);
    n_total++; if (q0 !== {64'h2C2C2C2C_2A2A2A2A, 64'h28282828_26262626, 64'h24242424_22222222})
      $display("FAIL b2b_q got %h", q0); else n_pass++;
    n_total++; if (av0 !== 1'b1) $display("FAIL b2b_all_valid got %b exp 1", av0); else n_pass++;
    zeroize = 1'b1; wr = 1'b1; data = 32'hFFFF_FFFF;
    tick();
    zeroize = 1'b0; wr = 1'b0;
    n_total++; if (q0 !== 192'h0) $display("FAIL zeroize_q got %h exp 0", q0); else n_pass++;
    n_total++; if ({kv0, av0, ov0, pe0} !== 8'h0) $display("FAIL zeroize_status got %b exp 0", {kv0, av0, ov0, pe0}); else n_pass++;
  endtask

  initial begin
    hreset = 1'b0; zeroize = 1'b0; clr = 1'b0; key2_mode = 1'b0; wr = 1'b0; data = 32'h0;
    test_reset();
    test_load_mode0();
    test_overflow_clr();
    test_parity_check();
    test_two_key();
    test_regen_and_midreset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
